// File: rtl/gals_prod_scheduler.sv
// GALS producer scheduler: selects the active producer (Fibonacci or timer)
// and paces it with a programmable-rate tick, stalling while the buffer is full.
module gals_prod_scheduler #(
  parameter int BASE_DIV = 4,
  parameter int CNT_W    = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_f,
  input  logic       start_t,
  input  logic       stop_f_t,
  input  logic       update,
  input  logic [2:0] prog,
  input  logic       buf_full,
  output logic       f_en,
  output logic       t_en,
  output logic       tick,
  output logic [2:0] prog_q,
  output logic [1:0] mode,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FIB  = 2'b01,
    TIM  = 2'b10,
    HOLD = 2'b11
  } state_t;

  state_t           state, state_d;
  logic             origin, origin_d;
  logic [CNT_W-1:0] div, div_d;
  logic [CNT_W-1:0] last;
  logic [2:0]       prog_d;
  logic             tick_d;

  assign last = (CNT_W'(BASE_DIV) << prog_q) - CNT_W'(1);

  always_comb begin
    state_d  = state;
    origin_d = origin;
    div_d    = div;
    prog_d   = prog_q;
    tick_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (update) prog_d = prog;
        if (!stop_f_t) begin
          if (start_f) begin
            state_d  = FIB;
            origin_d = 1'b0;
            div_d    = '0;
          end else if (start_t) begin
            state_d  = TIM;
            origin_d = 1'b1;
            div_d    = '0;
          end
        end
      end
      FIB, TIM: begin
        if (stop_f_t) begin
          state_d = IDLE;
        end else if (buf_full) begin
          state_d = HOLD;
        end else if (div == last) begin
          div_d  = '0;
          tick_d = 1'b1;
        end else begin
          div_d = div + CNT_W'(1);
        end
      end
      HOLD: begin
        // divider stays frozen so the resumed run loses no ticks
        if (stop_f_t) state_d = IDLE;
        else if (!buf_full) state_d = origin ? TIM : FIB;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      origin <= 1'b0;
      div    <= '0;
      prog_q <= '0;
      tick   <= 1'b0;
      f_en   <= 1'b0;
      t_en   <= 1'b0;
      mode   <= 2'b00;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      origin <= origin_d;
      div    <= div_d;
      prog_q <= prog_d;
      tick   <= tick_d;
      f_en   <= (state_d == FIB);
      t_en   <= (state_d == TIM);
      mode   <= state_d;
      busy   <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_gals_prod_scheduler.sv
// Directed testbench for gals_prod_scheduler.
// Inputs change and outputs are sampled just after the falling edge.
module tb_gals_prod_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_f = 1'b0;
  logic       start_t = 1'b0;
  logic       stop_f_t = 1'b0;
  logic       update = 1'b0;
  logic [2:0] prog = 3'd0;
  logic       buf_full = 1'b0;
  logic       f_en, t_en, tick, busy;
  logic [2:0] prog_q;
  logic [1:0] mode;

  int checks = 0;
  int fails  = 0;

  gals_prod_scheduler dut (
    .clock(clock), .reset(reset),
    .start_f(start_f), .start_t(start_t),
    .stop_f_t(stop_f_t), .update(update),
    .prog(prog), .buf_full(buf_full),
    .f_en(f_en), .t_en(t_en), .tick(tick),
    .prog_q(prog_q), .mode(mode), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (f_en && t_en) begin
        fails++;
        $display("FAIL excl_en: f_en=%b t_en=%b, required not both 1", f_en, t_en);
      end
    end
  end

  task automatic step();
    @(negedge clock);
    start_f  = 1'b0;
    start_t  = 1'b0;
    stop_f_t = 1'b0;
    update   = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if (tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({f_en, t_en, tick, prog_q, mode, busy} !== 9'b0) begin
      fails++;
      $display("FAIL reset_outs: got %b, required 0",
               {f_en, t_en, tick, prog_q, mode, busy});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_fib_rate();
    int n;
    logic t_seen;
    prog = 3'd3; update = 1'b1; start_f = 1'b1;
    step();
    checks++;
    if (mode !== 2'b01 || f_en !== 1'b1 || prog_q !== 3'd3) begin
      fails++;
      $display("FAIL fib_start: mode=%b f_en=%b prog_q=%0d, required 01 1 3",
               mode, f_en, prog_q);
    end
    t_seen = 1'b0;
    wait_tick(40, n);
    checks++;
    if (n !== 32) begin
      fails++;
      $display("FAIL fib_first_tick: at %0d, required 32", n);
    end
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      if (t_en) t_seen = 1'b1;
      if (tick) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 32 || t_seen !== 1'b0) begin
      fails++;
      $display("FAIL fib_period: %0d t_en_seen=%b, required 32 0", n, t_seen);
    end
  endtask

  task automatic test_no_switch();
    int n;
    start_t = 1'b1;
    step();
    checks++;
    if (mode !== 2'b01 || t_en !== 1'b0 || f_en !== 1'b1) begin
      fails++;
      $display("FAIL no_switch: mode=%b f_en=%b t_en=%b, required 01 1 0",
               mode, f_en, t_en);
    end
    stop_f_t = 1'b1;
    step();
    checks++;
    if (mode !== 2'b00 || f_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fib_stop: mode=%b f_en=%b busy=%b, required 00 0 0",
               mode, f_en, busy);
    end
    wait_tick(80, n);
    checks++;
    if (n !== -1) begin
      fails++;
      $display("FAIL idle_tick: tick at %0d, required none", n);
    end
  endtask

  task automatic test_prog_update();
    int n;
    start_t = 1'b1;
    step();
    prog = 3'd5; update = 1'b1;
    step();
    checks++;
    if (mode !== 2'b10 || prog_q !== 3'd3) begin
      fails++;
      $display("FAIL run_update: mode=%b prog_q=%0d, required 10 3", mode, prog_q);
    end
    stop_f_t = 1'b1;
    step();
    update = 1'b1;
    step();
    checks++;
    if (prog_q !== 3'd5) begin
      fails++;
      $display("FAIL idle_update: prog_q=%0d, required 5", prog_q);
    end
    start_t = 1'b1;
    step();
    wait_tick(200, n);
    checks++;
    if (n !== 128) begin
      fails++;
      $display("FAIL tim128_first: %0d, required 128", n);
    end
    wait_tick(200, n);
    checks++;
    if (n !== 128) begin
      fails++;
      $display("FAIL tim128_period: %0d, required 128", n);
    end
    stop_f_t = 1'b1;
    step();
  endtask

  task automatic test_hold();
    int n;
    logic bad;
    prog = 3'd0; update = 1'b1; start_t = 1'b1;
    step();
    step();
    step();
    buf_full = 1'b1;
    step();
    checks++;
    if (mode !== 2'b11 || t_en !== 1'b0 || tick !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL hold_enter: mode=%b t_en=%b tick=%b busy=%b, required 11 0 0 1",
               mode, t_en, tick, busy);
    end
    bad = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      if (tick || mode !== 2'b11) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL hold_stable: disturbed=%b, required 0", bad);
    end
    buf_full = 1'b0;
    step();
    checks++;
    if (mode !== 2'b10 || t_en !== 1'b1) begin
      fails++;
      $display("FAIL hold_resume: mode=%b t_en=%b, required 10 1", mode, t_en);
    end
    wait_tick(10, n);
    checks++;
    if (n !== 2) begin
      fails++;
      $display("FAIL resume_tick: %0d, required 2", n);
    end
    wait_tick(10, n);
    checks++;
    if (n !== 4) begin
      fails++;
      $display("FAIL resume_period: %0d, required 4", n);
    end
    stop_f_t = 1'b1;
    step();
  endtask

  task automatic test_priority();
    stop_f_t = 1'b1;
    step();
    checks++;
    if (mode !== 2'b00) begin
      fails++;
      $display("FAIL idle_stop: mode=%b, required 00", mode);
    end
    start_f = 1'b1; start_t = 1'b1;
    step();
    checks++;
    if (mode !== 2'b01 || f_en !== 1'b1 || t_en !== 1'b0) begin
      fails++;
      $display("FAIL both_start: mode=%b f_en=%b t_en=%b, required 01 1 0",
               mode, f_en, t_en);
    end
    stop_f_t = 1'b1; buf_full = 1'b1;
    step();
    buf_full = 1'b0;
    checks++;
    if (mode !== 2'b00 || f_en !== 1'b0) begin
      fails++;
      $display("FAIL stop_over_full: mode=%b f_en=%b, required 00 0", mode, f_en);
    end
  endtask

  task automatic test_async_reset();
    int n;
    prog = 3'd2; update = 1'b1; start_f = 1'b1;
    step();
    for (int i = 0; i < 10; i++) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({f_en, t_en, tick, prog_q, mode, busy} !== 9'b0) begin
      fails++;
      $display("FAIL async_reset: got %b, required 0",
               {f_en, t_en, tick, prog_q, mode, busy});
    end
    @(negedge clock);
    reset = 1'b0;
    start_t = 1'b1;
    step();
    wait_tick(10, n);
    checks++;
    if (n !== 4) begin
      fails++;
      $display("FAIL post_reset_first: %0d, required 4", n);
    end
    wait_tick(10, n);
    checks++;
    if (n !== 4) begin
      fails++;
      $display("FAIL post_reset_period: %0d, required 4", n);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tick !== 1'b0 || t_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_tick_drop: tick=%b t_en=%b, required 0 0", tick, t_en);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fib_rate();
    test_no_switch();
    test_prog_update();
    test_hold();
    test_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
